// File: rtl/tdm_pkg.sv
// tdm_pkg: shared TDM framing defaults, sample/frame types and transmitter states
package tdm_pkg;
  localparam int BIT_WIDTH = 24;
  localparam int SLOTS = 4;
  localparam int SLOT_BITS = 32;
  typedef logic [BIT_WIDTH-1:0] sample_t;
  typedef sample_t frame_t [SLOTS];
  typedef enum logic {IDLE, RUN} tx_state_t;
endpackage

// File: rtl/tdm_transmit_sck_gen.sv
// sck_gen: SCK phase counter with one-cycle rise/fall strobes, held low while disabled
module sck_gen #(
  parameter int HALF_PERIOD = 16
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic en,
  output logic sck_out,
  output logic rise,
  output logic fall
);
  localparam int PW = HALF_PERIOD > 1 ? $clog2(HALF_PERIOD) : 1;
  logic [PW-1:0] phase;
  logic wrap;
  assign wrap = en && phase == PW'(HALF_PERIOD - 1);
  assign rise = wrap && !sck_out;
  assign fall = wrap && sck_out;
  always_ff @(posedge clk_in) begin
    if (rst_in || !en) begin
      phase <= '0;
      sck_out <= 1'b0;
    end else begin
      phase <= wrap ? '0 : phase + 1'b1;
      sck_out <= sck_out ^ wrap;
    end
  end
endmodule

// File: rtl/tdm_transmit.sv
// tdm_transmit: TDM serial transmitter, one WS-prefixed frame of MSB-first slots per load
module tdm_transmit import tdm_pkg::*; #(
  parameter int BIT_WIDTH = tdm_pkg::BIT_WIDTH,
  parameter int SLOTS = tdm_pkg::SLOTS,
  parameter int SLOT_BITS = tdm_pkg::SLOT_BITS,
  parameter int HALF_PERIOD = 16
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic enable_in,
  input  logic [SLOTS-1:0][BIT_WIDTH-1:0] audio_in,
  input  logic audio_valid_in,
  output logic ready_out,
  output logic sck_out,
  output logic ws_out,
  output logic sd_out,
  output logic frame_start_out,
  output logic underrun_out
);
  localparam int LAST = SLOTS * SLOT_BITS;
  localparam int IW = $clog2(LAST + 1);
  localparam int PW = $clog2(SLOT_BITS + 1);
  localparam int FW = SLOTS * BIT_WIDTH;
  tx_state_t state, next_state;
  logic [SLOTS-1:0][BIT_WIDTH-1:0] hold, active, src;
  logic [FW-1:0] shreg, src_bits;
  logic [IW-1:0] bit_idx;
  logic [PW-1:0] pos;
  logic hold_full, accept, load, frame_end, fall, in_word, sck_rise_unused;
  sck_gen #(.HALF_PERIOD(HALF_PERIOD)) u_sck (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .en(state == RUN),
    .sck_out(sck_out),
    .rise(sck_rise_unused),
    .fall(fall)
  );
  assign ready_out = !hold_full;
  assign accept = audio_valid_in && !hold_full;
  assign frame_end = fall && bit_idx == IW'(LAST);
  assign load = enable_in && (state == IDLE || frame_end);
  assign in_word = pos < PW'(BIT_WIDTH);
  assign src = hold_full ? hold : active;
  always_comb next_state = load ? RUN : (frame_end ? IDLE : state);
  // slot 0 occupies the top of the shift register so it leaves first
  always_comb begin
    src_bits = '0;
    for (int s = 0; s < SLOTS; s++) src_bits[(SLOTS-s)*BIT_WIDTH-1 -: BIT_WIDTH] = src[s];
  end
  always_ff @(posedge clk_in) state <= rst_in ? IDLE : next_state;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hold <= '0;
      active <= '0;
      shreg <= '0;
      hold_full <= 1'b0;
      bit_idx <= '0;
      pos <= '0;
      ws_out <= 1'b0;
      sd_out <= 1'b0;
      frame_start_out <= 1'b0;
      underrun_out <= 1'b0;
    end else begin
      frame_start_out <= load;
      underrun_out <= load && !hold_full;
      if (accept) hold <= audio_in;
      hold_full <= accept || (hold_full && !load);
      if (load) begin
        active <= src;
        shreg <= src_bits;
        bit_idx <= '0;
        pos <= '0;
        ws_out <= 1'b1;
        sd_out <= 1'b0;
      end else if (frame_end) begin
        bit_idx <= '0;
        ws_out <= 1'b0;
        sd_out <= 1'b0;
      end else if (fall) begin
        bit_idx <= bit_idx + 1'b1;
        pos <= pos == PW'(SLOT_BITS - 1) ? '0 : pos + 1'b1;
        ws_out <= 1'b0;
        sd_out <= in_word && shreg[FW-1];
        if (in_word) shreg <= shreg << 1;
      end
    end
  end
endmodule

// File: tb/tb_tdm_transmit.sv
// tb_tdm_transmit: frame-level model compared every cycle, plus literal frame captures
module tb_tdm_transmit;
  localparam int HP = 2;
  localparam int FLEN = 129 * 2 * HP;
  logic clk = 0, rst = 1, enable = 0, valid = 0;
  logic [3:0][23:0] audio = '0;
  logic ready_out, sck_out, ws_out, sd_out, frame_start_out, underrun_out;
  int tests = 0, fails = 0;
  bit chk_on = 0;
  tdm_transmit #(.BIT_WIDTH(24), .SLOTS(4), .SLOT_BITS(32), .HALF_PERIOD(HP)) dut (
    .clk_in(clk), .rst_in(rst), .enable_in(enable), .audio_in(audio),
    .audio_valid_in(valid), .ready_out(ready_out), .sck_out(sck_out), .ws_out(ws_out),
    .sd_out(sd_out), .frame_start_out(frame_start_out), .underrun_out(underrun_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // model: cycle count c since the last load, active/holding frames as plain arrays
  bit m_run = 0, m_hf = 0, m_ur = 0;
  int c = 0;
  logic [3:0][23:0] m_act = '0, m_hold = '0;
  always @(posedge clk) begin
    bit acc, bnd;
    acc = valid && !m_hf;
    if (rst) begin
      m_run = 0; c = 0; m_hf = 0; m_ur = 0; m_act = '0; m_hold = '0;
    end else begin
      bnd = m_run && c == FLEN - 1;
      if (m_run && !bnd) c++;
      else if (enable) begin
        m_run = 1; c = 0; m_ur = !m_hf;
        if (m_hf) begin m_act = m_hold; m_hf = 0; end
      end else begin
        m_run = 0; c = 0;
      end
      if (acc) begin m_hf = 1; m_hold = audio; end
    end
  end
  always @(negedge clk) if (chk_on) begin
    int p, k;
    logic e_sd;
    p = c / (2 * HP);
    k = p - 1;
    e_sd = m_run && p > 0 && (k % 32) < 24 && m_act[k / 32][23 - (k % 32)];
    check("sck", 96'(sck_out), 96'(m_run && ((c / HP) % 2 == 1)));
    check("ws", 96'(ws_out), 96'(m_run && p == 0));
    check("sd", 96'(sd_out), 96'(e_sd));
    check("frame_start", 96'(frame_start_out), 96'(m_run && c == 0));
    check("underrun", 96'(underrun_out), 96'(m_run && c == 0 && m_ur));
    check("ready", 96'(ready_out), 96'(!m_hf));
  end
  function automatic logic [3:0][23:0] pat(input int i);
    logic [3:0][23:0] w;
    for (int s = 0; s < 4; s++) w[s] = 24'(32'h0A0B0C + i * 32'h010203 + s * 32'h100000);
    return w;
  endfunction
  // capture one frame from its frame_start, sampling sd and ws on each SCK rise
  task automatic grab(output logic [3:0][23:0] w, output bit ur, output bit ws_ok,
                      output bit pad_ok, output int period);
    int t, n, last, k;
    bit prev;
    w = '0; ur = 0; ws_ok = 1; pad_ok = 1; period = 0; t = 0; n = 0; last = 0;
    @(negedge clk);
    while (!frame_start_out && t < 2000) begin @(negedge clk); t++; end
    check("grab_start_timeout", 96'(frame_start_out), 96'(1));
    ur = underrun_out;
    prev = sck_out;
    t = 0;
    while (n < 129 && t < 1000) begin
      @(negedge clk);
      t++;
      if (sck_out && !prev) begin
        ws_ok &= (n == 0) ? ws_out : !ws_out;
        if (n > 0) begin
          k = n - 1;
          if (k % 32 < 24) w[k / 32][23 - (k % 32)] = sd_out;
          else if (sd_out) pad_ok = 0;
        end
        if (n == 2) period = t - last;
        last = t;
        n++;
      end
      prev = sck_out;
    end
    check("grab_rise_count", 96'(n), 96'(129));
  endtask
  task automatic check_frame(input string name, input logic [3:0][23:0] exp, input bit exp_ur);
    logic [3:0][23:0] w;
    bit ur, ws_ok, pad_ok;
    int period;
    grab(w, ur, ws_ok, pad_ok, period);
    check({name, "_words"}, 96'(w), 96'(exp));
    check({name, "_underrun"}, 96'(ur), 96'(exp_ur));
    check({name, "_ws"}, 96'(ws_ok), 96'(1));
    check({name, "_pad"}, 96'(pad_ok), 96'(1));
    check({name, "_period"}, 96'(period), 96'(4));
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_ready_low();
    int t = 0;
    while (ready_out && t < 2000) begin tick(1); t++; end
    check("accept_timeout", 96'(ready_out), 96'(0));
  endtask
  logic [3:0][23:0] p0, px;
  int n, t;
  bit prev;
  initial begin
    p0[0] = 24'hABCDEF; p0[1] = 24'h123456; p0[2] = 24'h800001; p0[3] = 24'h7FFFFF;
    px[0] = 24'h000001; px[1] = 24'h800000; px[2] = 24'hFFFFFF; px[3] = 24'h5A5A5A;
    tick(3);
    chk_on = 1;
    check("rst_outs", 96'({sck_out, ws_out, sd_out, frame_start_out, underrun_out}), 96'(0));
    check("rst_ready", 96'(ready_out), 96'(1));
    rst = 0;
    tick(2);
    enable = 1;
    n = 0;
    do begin tick(1); n++; end while (!sck_out && n < 20);
    check("first_rise_latency", 96'(n), 96'(1 + HP));
    check_frame("empty", '0, 1);
    valid = 1; audio = p0;
    wait_ready_low();
    valid = 0;
    check_frame("loaded", p0, 0);
    valid = 1; audio = pat(1);
    wait_ready_low();
    audio = pat(2);
    for (int i = 1; i <= 3; i++) begin
      check_frame($sformatf("stream%0d", i), pat(i), 0);
      audio = pat(i + 2);
    end
    valid = 0;
    t = 0;
    @(negedge clk);
    while (!frame_start_out && t < 2000) begin @(negedge clk); t++; end
    n = 0; t = 0; prev = sck_out;
    while (t < 700) begin
      @(negedge clk);
      t++;
      if (sck_out && !prev) n++;
      if (n == 41) enable = 0;
      prev = sck_out;
    end
    check("drop_enable_rises", 96'(n), 96'(129));
    check("idle_outs", 96'({sck_out, ws_out, sd_out, frame_start_out}), 96'(0));
    tick(1);
    enable = 1;
    t = 0;
    @(negedge clk);
    while (!frame_start_out && t < 100) begin @(negedge clk); t++; end
    tick(10 * 4);
    valid = 1; audio = pat(9);
    wait_ready_low();
    valid = 0;
    tick(60 * 4);
    rst = 1; enable = 0;
    tick(1);
    check("midrst_outs", 96'({sck_out, ws_out, sd_out, frame_start_out, underrun_out}), 96'(0));
    check("midrst_ready", 96'(ready_out), 96'(1));
    rst = 0;
    tick(1);
    enable = 1;
    check_frame("after_rst", '0, 1);
    t = 0;
    @(negedge clk);
    while (!frame_start_out && t < 2000) begin @(negedge clk); t++; end
    tick(FLEN - 1);
    valid = 1; audio = px;
    tick(1);
    valid = 0;
    check("coincident_accept_ready", 96'(ready_out), 96'(0));
    check_frame("coincident_repeat", '0, 1);
    check_frame("coincident_next", px, 0);
    enable = 0;
    tick(FLEN + 20);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
